// File: rtl/reg_debug_port.sv
// Debug-side initiator for the 8x16 register unit: dumps all registers to a
// valid/ready stream or loads all registers from one, always in order 0..N-1.
module reg_debug_port #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic                  cmd_op,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  ru_en,
    output logic                  ru_wr_en,
    output logic                  ru_rS_wr_en,
    output logic [SEL_WIDTH-1:0]  ru_rD_sel,
    output logic [DATA_WIDTH-1:0] ru_rD_data_in,
    output logic [SEL_WIDTH-1:0]  ru_rS_sel,
    input  logic [DATA_WIDTH-1:0] ru_rS_data_out
);
    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // RD    | read strobe for register idx
    // CAP   | capture registered read data into out_data
    // OUT   | present out_data until the sink takes it
    // LWAIT | waiting for the next load word
    // WR    | single-cycle write strobe of word into register idx
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_CAP, S_OUT, S_LWAIT, S_WR, S_DONE
    } state_t;

    state_t                state, state_nx;
    logic [SEL_WIDTH-1:0]  idx;
    logic [DATA_WIDTH-1:0] word;
    logic                  last;

    assign last        = (idx == {SEL_WIDTH{1'b1}});
    assign ru_rS_wr_en = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            out_data <= '0;
            word     <= '0;
        end else begin
            case (state)
                S_IDLE:  if (cmd_valid) idx <= '0;
                S_CAP:   out_data <= ru_rS_data_out;
                S_OUT:   if (out_ready && !last) idx <= idx + SEL_WIDTH'(1);
                S_LWAIT: if (in_valid) word <= in_data;
                S_WR:    if (!last) idx <= idx + SEL_WIDTH'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nx = cmd_op ? S_LWAIT : S_RD;
            S_RD:    state_nx = S_CAP;
            S_CAP:   state_nx = S_OUT;
            S_OUT:   if (out_ready) state_nx = last ? S_DONE : S_RD;
            S_LWAIT: if (in_valid) state_nx = S_WR;
            S_WR:    state_nx = last ? S_DONE : S_LWAIT;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Everything is forced low while rst is high, whatever the state register holds.
    always_comb begin
        cmd_ready     = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        out_valid     = 1'b0;
        in_ready      = 1'b0;
        ru_en         = 1'b0;
        ru_wr_en      = 1'b0;
        ru_rD_sel     = '0;
        ru_rD_data_in = '0;
        ru_rS_sel     = '0;
        if (!rst) begin
            busy = (state != S_IDLE);
            case (state)
                S_IDLE:  cmd_ready = 1'b1;
                S_RD: begin
                    ru_en     = 1'b1;
                    ru_rS_sel = idx;
                end
                S_OUT:   out_valid = 1'b1;
                S_LWAIT: in_ready = 1'b1;
                S_WR: begin
                    ru_en         = 1'b1;
                    ru_wr_en      = 1'b1;
                    ru_rD_sel     = idx;
                    ru_rD_data_in = word;
                end
                S_DONE:  done = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_debug_port.sv
// Randomized bench for reg_debug_port: a behavioural register unit plus an
// expected-contents array; loads and dumps are checked word by word.
module tb_reg_debug_port;
    localparam int DW   = 16;
    localparam int SW   = 3;
    localparam int NREG = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_op, cmd_ready;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready;
    logic          busy, done, ru_en, ru_wr_en, ru_rS_wr_en;
    logic [SW-1:0] ru_rD_sel, ru_rS_sel;
    logic [DW-1:0] ru_rD_data_in, ru_rS_data_out;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            wr_next;
    int            nw;
    logic [DW-1:0] ru_mem   [NREG];
    logic [DW-1:0] mem_exp  [NREG];
    logic [DW-1:0] ld_words [NREG];

    always #5 clk = ~clk;

    reg_debug_port #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done),
        .ru_en(ru_en), .ru_wr_en(ru_wr_en), .ru_rS_wr_en(ru_rS_wr_en),
        .ru_rD_sel(ru_rD_sel), .ru_rD_data_in(ru_rD_data_in),
        .ru_rS_sel(ru_rS_sel), .ru_rS_data_out(ru_rS_data_out)
    );

    // Register unit: synchronous write, registered read.
    always @(posedge clk) begin
        if (ru_en && ru_wr_en) ru_mem[ru_rD_sel] <= ru_rD_data_in;
        if (ru_en) ru_rS_data_out <= ru_mem[ru_rS_sel];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and check the per-cycle invariants.
    task automatic tick();
        logic          stall;
        logic [DW-1:0] held;
        stall = out_valid && !out_ready;
        held  = out_data;
        @(negedge clk);
        if (stall) chk("out_hold", 32'({out_valid, out_data}), 32'({1'b1, held}));
        chk("hs_excl", 32'($countones({cmd_ready, in_ready, out_valid}) <= 1), 1);
        chk("rs_wr_en", 32'(ru_rS_wr_en), 0);
        if (!ru_en) chk("ru_quiet", 32'({ru_wr_en, ru_rD_sel, ru_rS_sel, ru_rD_data_in}), 0);
        if (ru_wr_en) begin
            if (wr_next < NREG) begin
                chk("wr_sel", 32'(ru_rD_sel), wr_next);
                chk("wr_data", 32'(ru_rD_data_in), 32'(ld_words[wr_next]));
                wr_next++;
            end else begin
                chk("wr_extra", 32'(ru_wr_en), 0);
            end
        end
    endtask

    task automatic reset_phase(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            cmd_valid = (i == cycles - 1) ? 1'b1 : 1'($urandom);
            cmd_op    = 1'($urandom);
            in_valid  = 1'($urandom);
            in_data   = DW'($urandom);
            out_ready = 1'($urandom);
            tick();
            chk("rst_outs", 32'({cmd_ready, busy, done, out_valid, in_ready, ru_en, ru_wr_en}), 0);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("post_rst", 32'({cmd_ready, busy}), 2);
    endtask

    task automatic start_cmd(input logic op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_accept", 32'({busy, cmd_ready}), 2);
    endtask

    // mode 0: in_valid high, 1: 5-cycle gap before word 3, 2: random in_valid
    task automatic do_load(input int mode, input int abort_after, output int n_written);
        int   k, sent, gap, done_k, last_wr_k;
        logic hs;
        k = 0; sent = 0; gap = 0; done_k = -1; last_wr_k = -10;
        wr_next = 0;
        start_cmd(1'b1);
        k = 1;
        while (k < 400 && done_k < 0) begin
            if (sent >= NREG)                          in_valid = 1'($urandom);
            else if (mode == 1 && sent == 3 && gap < 5) begin in_valid = 1'b0; gap++; end
            else if (mode == 2)                        in_valid = 1'($urandom);
            else                                       in_valid = 1'b1;
            in_data = (in_valid && sent < NREG) ? ld_words[sent] : DW'($urandom);
            hs = in_valid && in_ready;
            tick();
            k++;
            chk("ld_wr_lat", 32'(ru_wr_en), 32'(hs));
            chk("ld_done", 32'(done), 32'(k == last_wr_k + 1));
            if (hs) begin
                if (sent == NREG - 1) last_wr_k = k;
                sent++;
            end
            if (done) done_k = k;
            if (abort_after >= 0 && wr_next == abort_after + 1) begin
                n_written = wr_next;
                wr_next   = NREG;
                in_valid  = 1'b0;
                tick();
                reset_phase(2);
                chk("abort_idle", 32'({cmd_ready, busy}), 2);
                return;
            end
        end
        in_valid  = 1'b0;
        n_written = wr_next;
        chk("ld_finished", 32'(done_k >= 0), 1);
        chk("ld_writes", wr_next, NREG);
        if (mode == 0) chk("ld_done_k", done_k, 17);
        wr_next = NREG;
        tick();
        chk("ld_idle", 32'({cmd_ready, busy}), 2);
    endtask

    // mode 0: out_ready high, 1: random out_ready; poke drives a load command while busy
    task automatic do_dump(input int mode, input bit poke);
        int k, got, first_k, done_k;
        got = 0; first_k = -1; done_k = -1;
        wr_next = NREG;
        start_cmd(1'b0);
        k = 1;
        if (poke) begin
            cmd_valid = 1'b1;
            cmd_op    = 1'b1;
        end
        while (k < 1000 && done_k < 0) begin
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom);
            if (out_valid && first_k < 0) first_k = k;
            if (out_valid && out_ready) begin
                if (got < NREG) chk("dump_word", 32'(out_data), 32'(mem_exp[got]));
                else            chk("dump_extra", 32'(out_valid), 0);
                got++;
            end
            tick();
            k++;
            if (poke) chk("busy_no_ready", 32'(cmd_ready), 0);
            if (done) begin
                done_k    = k;
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        chk("dump_finished", 32'(done_k >= 0), 1);
        chk("dump_count", got, NREG);
        if (mode == 0) begin
            chk("first_out_valid", first_k, 3);
            chk("dump_done_k", done_k, 25);
        end
        tick();
        chk("dump_idle", 32'({cmd_ready, busy}), 2);
    endtask

    task automatic rand_words();
        for (int i = 0; i < NREG; i++) ld_words[i] = DW'($urandom);
    endtask

    task automatic commit(input int n);
        for (int i = 0; i < n; i++) mem_exp[i] = ld_words[i];
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        wr_next = NREG;
        reset_phase(2);

        for (int i = 0; i < NREG; i++) ld_words[i] = 16'h1000 + DW'(i);
        do_load(0, -1, nw);
        commit(nw);
        do_dump(0, 1'b0);

        do_dump(1, 1'b1);

        rand_words();
        do_load(1, -1, nw);
        commit(nw);
        do_dump(1, 1'b0);

        rand_words();
        do_load(0, 4, nw);
        chk("abort_written", nw, 5);
        commit(nw);
        do_dump(0, 1'b0);

        for (int r = 0; r < 3; r++) begin
            rand_words();
            do_load(2, -1, nw);
            commit(nw);
            do_dump(1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
